// File: rtl/seq_fases_ctrl.sv
// Phase sequencer for the shared time-base counter.
// Walks a fixed 4-phase cycle, loading each phase duration into the time base
// and advancing on its end-of-count. The cycle repeats n_rep times (0 = until
// abort). All outputs are registered.
module seq_fases_ctrl #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [4*N-1:0] dur,
  input  logic [R-1:0]   n_rep,
  input  logic           tb_eo,
  output logic           tb_st,
  output logic [N-1:0]   tb_dat,
  output logic           tb_rst,
  output logic [3:0]     phase_en,
  output logic [1:0]     phase_idx,
  output logic [R-1:0]   rep_cnt,
  output logic           busy,
  output logic           done,
  output logic           aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DONE,
    S_ABT
  } state_t;

  state_t         r_state;
  logic [4*N-1:0] r_dur_q;
  logic [R-1:0]   r_rep_q;

  logic           r_tb_st;
  logic [N-1:0]   r_tb_dat;
  logic           r_tb_rst;
  logic [3:0]     r_phase_en;
  logic [1:0]     r_phase_idx;
  logic [R-1:0]   r_rep_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_aborted;

  logic [1:0]     w_next_idx;
  logic [R-1:0]   w_rep_next;
  logic           w_last_rep;

  // Duration of phase k from the latched duration vector.
  function automatic logic [N-1:0] dur_of(input logic [4*N-1:0] d,
                                          input logic [1:0]     k);
    return d[k*N +: N];
  endfunction

  // Next-phase index, incremented repetition count and last-repetition test.
  always_comb begin
    w_next_idx = r_phase_idx + 2'd1;
    w_rep_next = r_rep_cnt + R'(1);
    w_last_rep = (r_rep_q != '0) && (w_rep_next == r_rep_q);
  end

  // Sequencer FSM; each transition also sets the registered outputs of the
  // state being entered, so outputs line up with the state without a
  // separate decode stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dur_q     <= '0;
      r_rep_q     <= '0;
      r_tb_st     <= 1'b0;
      r_tb_dat    <= '0;
      r_tb_rst    <= 1'b0;
      r_phase_en  <= '0;
      r_phase_idx <= '0;
      r_rep_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_tb_st    <= 1'b0;
          r_tb_dat   <= '0;
          r_tb_rst   <= 1'b0;
          r_phase_en <= '0;
          r_busy     <= 1'b0;
          if (start && !abort) begin
            r_dur_q     <= dur;
            r_rep_q     <= n_rep;
            r_rep_cnt   <= '0;
            r_phase_idx <= '0;
            r_tb_rst    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_CLR;
          end
        end

        S_CLR: begin
          if (abort) begin
            r_tb_rst   <= 1'b1;
            r_tb_st    <= 1'b0;
            r_tb_dat   <= '0;
            r_phase_en <= '0;
            r_busy     <= 1'b0;
            r_aborted  <= 1'b1;
            r_state    <= S_ABT;
          end else begin
            r_tb_rst    <= 1'b0;
            r_tb_st     <= 1'b1;
            r_tb_dat    <= dur_of(r_dur_q, 2'd0);
            r_phase_en  <= 4'b0001;
            r_phase_idx <= 2'd0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end

        S_RUN: begin
          // abort wins over a coincident end-of-count: phase is not advanced
          if (abort) begin
            r_tb_rst   <= 1'b1;
            r_tb_st    <= 1'b0;
            r_tb_dat   <= '0;
            r_phase_en <= '0;
            r_busy     <= 1'b0;
            r_aborted  <= 1'b1;
            r_state    <= S_ABT;
          end else if (tb_eo) begin
            if (r_phase_idx != 2'd3) begin
              r_phase_idx <= w_next_idx;
              r_tb_dat    <= dur_of(r_dur_q, w_next_idx);
              r_phase_en  <= 4'b0001 << w_next_idx;
            end else begin
              r_phase_idx <= 2'd0;
              r_rep_cnt   <= w_rep_next;
              if (w_last_rep) begin
                r_tb_st    <= 1'b0;
                r_tb_dat   <= '0;
                r_phase_en <= '0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= S_DONE;
              end else begin
                r_tb_dat   <= dur_of(r_dur_q, 2'd0);
                r_phase_en <= 4'b0001;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        S_ABT: begin
          r_tb_rst <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_tb_st    <= 1'b0;
          r_tb_dat   <= '0;
          r_tb_rst   <= 1'b0;
          r_phase_en <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tb_st     = r_tb_st;
  assign tb_dat    = r_tb_dat;
  assign tb_rst    = r_tb_rst;
  assign phase_en  = r_phase_en;
  assign phase_idx = r_phase_idx;
  assign rep_cnt   = r_rep_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_seq_fases_ctrl.sv
// Bench for seq_fases_ctrl: behavioural time base plus a queue of expected
// per-cycle output vectors built from the phase durations.
module tb_seq_fases_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] dur;
  logic [7:0]  n_rep;
  logic        tb_eo;
  logic        tb_st;
  logic [7:0]  tb_dat;
  logic        tb_rst;
  logic [3:0]  phase_en;
  logic [1:0]  phase_idx;
  logic [7:0]  rep_cnt;
  logic        busy;
  logic        done;
  logic        aborted;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic       st;
    logic [7:0] dat;
    logic       trst;
    logic [3:0] pe;
    logic [1:0] pi;
    logic [7:0] rc;
    logic       busy;
    logic       done;
    logic       ab;
  } vec_t;

  vec_t exp_q[$];

  seq_fases_ctrl #(.N(8), .R(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dur(dur),
    .n_rep(n_rep), .tb_eo(tb_eo), .tb_st(tb_st), .tb_dat(tb_dat),
    .tb_rst(tb_rst), .phase_en(phase_en), .phase_idx(phase_idx),
    .rep_cnt(rep_cnt), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Time-base model: async active-high clear, self-clears at terminal count.
  logic [7:0] tb_cnt;
  always @(posedge clk or posedge tb_rst) begin
    if (tb_rst)      tb_cnt <= 8'd0;
    else if (tb_eo)  tb_cnt <= 8'd0;
    else if (tb_st)  tb_cnt <= tb_cnt + 8'd1;
  end
  assign tb_eo = (tb_cnt == tb_dat);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic st, logic [7:0] dat, logic trst,
                              logic [3:0] pe, logic [1:0] pi, logic [7:0] rc,
                              logic b, logic d, logic a);
    return '{st: st, dat: dat, trst: trst, pe: pe, pi: pi, rc: rc,
             busy: b, done: d, ab: a};
  endfunction

  task automatic push(input vec_t v);
    exp_q.push_back(v);
  endtask

  task automatic push_clr();
    push(mk(1'b0, 8'd0, 1'b1, 4'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic push_phase(input int k, input logic [7:0] d, input logic [7:0] r);
    logic [3:0] pe;
    pe = 4'b0001 << k;
    for (int c = 0; c <= int'(d); c++)
      push(mk(1'b1, d, 1'b0, pe, 2'(k), r, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic push_idle(input logic [1:0] pi, input logic [7:0] rc);
    push(mk(1'b0, 8'd0, 1'b0, 4'd0, pi, rc, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_abt(input logic [1:0] pi, input logic [7:0] rc);
    push(mk(1'b0, 8'd0, 1'b1, 4'd0, pi, rc, 1'b0, 1'b0, 1'b1));
  endtask

  // Whole sequence from the start edge: CLR, all repetitions, DONE, one IDLE.
  task automatic push_full(input logic [31:0] dv, input logic [7:0] nr);
    logic [7:0] d;
    push_clr();
    for (int r = 0; r < int'(nr); r++)
      for (int k = 0; k < 4; k++) begin
        d = dv[8*k +: 8];
        push_phase(k, d, 8'(r));
      end
    push(mk(1'b0, 8'd0, 1'b0, 4'd0, 2'd0, nr, 1'b0, 1'b1, 1'b0));
    push_idle(2'd0, nr);
  endtask

  // One clock: let the edge happen, then compare outputs to the queue head.
  task automatic tick(input string tag);
    vec_t obs;
    vec_t e;
    @(posedge clk);
    @(negedge clk);
    obs = mk(tb_st, tb_dat, tb_rst, phase_en, phase_idx, rep_cnt, busy, done, aborted);
    n_chk++;
    assert (exp_q.size() > 0)
    else begin
      n_err++;
      $error("FAIL %s: observed output %h but expected-queue is empty", tag, obs);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      assert (obs === e)
      else begin
        n_err++;
        $error("FAIL %s: observed st/dat/rst/pe/pi/rc/busy/done/ab=%h expected=%h",
               tag, obs, e);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic e);
    n_chk++;
    assert (obs === e)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic check_cnt0(input string tag);
    n_chk++;
    assert (tb_cnt === 8'd0)
    else begin
      n_err++;
      $error("FAIL %s: time-base count observed=%0d expected=0", tag, tb_cnt);
    end
  endtask

  localparam logic [31:0] BASIC = {8'd1, 8'd3, 8'd0, 8'd2};

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; dur = '0; n_rep = '0;

    // reset state
    push_idle(2'd0, 8'd0);
    push_idle(2'd0, 8'd0);
    drain("reset");
    rst = 1'b1;

    // basic run
    dur = BASIC; n_rep = 8'd2;
    push_full(BASIC, 8'd2);
    start = 1'b1;
    tick("basic_clr");
    start = 1'b0;
    drain("basic");

    // start+abort together in IDLE: nothing happens
    start = 1'b1; abort = 1'b1;
    push_idle(2'd0, 8'd2);
    tick("start_abort_idle");
    start = 1'b0; abort = 1'b0;
    push_idle(2'd0, 8'd2);
    tick("start_abort_idle2");

    // abort during phase 2 of repetition 0
    push_clr();
    push_phase(0, 8'd2, 8'd0);
    push_phase(1, 8'd0, 8'd0);
    push(mk(1'b1, 8'd3, 1'b0, 4'b0100, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0));
    push(mk(1'b1, 8'd3, 1'b0, 4'b0100, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0));
    start = 1'b1;
    tick("abort_clr");
    start = 1'b0;
    drain("abort_run");
    abort = 1'b1;
    push_abt(2'd2, 8'd0);
    tick("abort_abt");
    abort = 1'b0;
    push_idle(2'd2, 8'd0);
    drain("abort_idle");
    check_cnt0("abort_cnt");

    // reset mid-run
    push_clr();
    push_phase(0, 8'd2, 8'd0);
    push_phase(1, 8'd0, 8'd0);
    start = 1'b1;
    tick("rstmid_clr");
    start = 1'b0;
    drain("rstmid_run");
    rst = 1'b0;
    push_idle(2'd0, 8'd0);
    tick("rstmid_reset");
    rst = 1'b1;

    // restart after reset; start and dur/n_rep changes mid-run are ignored
    push_full(BASIC, 8'd2);
    start = 1'b1;
    tick("rerun_clr");
    start = 1'b0;
    tick("rerun");
    tick("rerun");
    start = 1'b1; dur = 32'hFFFF_FFFF; n_rep = 8'd5;
    tick("rerun_start_ignored");
    tick("rerun_start_ignored");
    tick("rerun_start_ignored");
    start = 1'b0;
    drain("rerun_dur_changed");
    dur = BASIC; n_rep = 8'd2;

    // abort together with tb_eo at the end of phase 0
    push_clr();
    push_phase(0, 8'd2, 8'd0);
    start = 1'b1;
    tick("abteo_clr");
    start = 1'b0;
    drain("abteo_run");
    check_bit("abteo_eo_high", tb_eo, 1'b1);
    abort = 1'b1;
    push_abt(2'd0, 8'd0);
    tick("abteo_abt");
    abort = 1'b0;
    push_idle(2'd0, 8'd0);
    drain("abteo_idle");
    check_cnt0("abteo_cnt");

    // continuous mode, all durations 0, rep_cnt wraps 255 -> 0
    dur = '0; n_rep = 8'd0;
    push_clr();
    for (int i = 0; i < 1030; i++)
      push(mk(1'b1, 8'd0, 1'b0, 4'b0001 << (i % 4), 2'(i % 4), 8'((i / 4) % 256),
              1'b1, 1'b0, 1'b0));
    start = 1'b1;
    tick("cont_clr");
    start = 1'b0;
    drain("cont_run");
    abort = 1'b1;
    push_abt(2'd1, 8'd1);
    tick("cont_abt");
    abort = 1'b0;
    push_idle(2'd1, 8'd1);
    drain("cont_idle");

    // max duration on phase 0
    dur = {8'd0, 8'd0, 8'd0, 8'd255}; n_rep = 8'd1;
    push_full({8'd0, 8'd0, 8'd0, 8'd255}, 8'd1);
    start = 1'b1;
    tick("maxdur_clr");
    start = 1'b0;
    drain("maxdur");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seq_fases_ctrl.md
Name: seq_fases_ctrl

Overview:
- Phase sequencer that drives the team's existing time-base counter through a fixed 4-phase cycle, e.g. lamp on / settle / measure / off.
- The time base has these ports:
  - st: count enable.
  - dat: terminal value.
  - eo: combinational, high while count == dat. The count clears to 0 on the next edge when eo is high.
  - rst: async, active-high.
- This block latches four phase durations and a repetition count on start. It loads each duration into the time base and advances the phase on each eo. It repeats the cycle, then signals completion.
- It is the only owner of the time base; the datapath consumes the one-hot phase enables.

Parameters:
N, 8, width of each phase duration and of tb_dat
R, 8, width of the repetition count and rep_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin a sequence; sampled only in IDLE
abort  in  1  stop the sequence; sampled in CLR and RUN
dur  in  4*N  phase k duration D_k at dur[k*N +: N]
n_rep  in  R  number of 4-phase repetitions; 0 = run until abort
tb_eo  in  1  end-of-count from the time base
tb_st  out  1  count enable to the time base
tb_dat  out  N  terminal value to the time base
tb_rst  out  1  clear pulse to the time base, active-high
phase_en  out  4  one-hot active phase; 0 when not in RUN
phase_idx  out  2  current phase index
rep_cnt  out  R  completed repetitions in the current sequence
busy  out  1  high in CLR and RUN
done  out  1  1-cycle pulse at normal completion
aborted  out  1  1-cycle pulse after an abort

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, all outputs 0, dur_q/rep_q=0. Reset has priority over every other input.
- All outputs are registered. tb_dat = dur_q[phase_idx] when in RUN, 0 otherwise.
- FSM states: IDLE, CLR, RUN, DONE, ABT.
- IDLE:
  - start=1 and abort=0 at an edge: latch dur into dur_q and n_rep into rep_q; rep_cnt=0, phase_idx=0; go to CLR.
  - start=1 and abort=1 together: stay in IDLE, no pulse.
- CLR (1 cycle): tb_rst=1, busy=1, tb_st=0. Then go to RUN with phase 0. abort here goes to ABT.
- RUN:
  - tb_st=1, busy=1, tb_dat=D_phase, phase_en=1<<phase_idx.
  - The time base starts at 0, so phase k occupies exactly D_k+1 cycles. tb_eo is high in the last of those cycles. D_k=0 gives a 1-cycle phase.
  - On tb_eo=1:
    - phase_idx<3: phase_idx+1.
    - phase_idx=3: phase_idx=0 and rep_cnt+1.
    - Last repetition complete (rep_q≠0 and rep_cnt+1==rep_q): go to DONE and hold rep_cnt at rep_q.
  - Phases run back-to-back with no gap, because the time base self-clears on the same edge.
- rep_q=0: run forever. rep_cnt wraps modulo 2^R and never causes DONE.
- DONE (1 cycle): done=1, busy=0, tb_st=0, phase_en=0, rep_cnt held. Then go to IDLE. start is ignored in this cycle.
- ABT (1 cycle): aborted=1, tb_rst=1, busy=0, tb_st=0, phase_en=0. Then go to IDLE. rep_cnt keeps its partial value.
- abort has priority over tb_eo in the same cycle.
- tb_eo is ignored outside RUN.
- Changes on dur/n_rep while busy have no effect; the values were latched at start.
- start while busy is ignored.
- rep_cnt holds until the next accepted start.

Test Plan:
- Basic run (bench time-base model per the Overview): D0..D3 = 2,0,3,1; n_rep=2; start at edge k.
  - tb_rst at k+1.
  - RUN k+2..k+21 (10 cycles per repetition).
  - phase_en sequence 0001×3, 0010×1, 0100×4, 1000×2, repeated twice.
  - done at k+22; busy=0 and rep_cnt=2 after.
- Abort: abort during phase 2 of repetition 0.
  - Next cycle: aborted=1, tb_rst=1, phase_en=0, rep_cnt=0.
  - Then IDLE.
  - The time-base count reads 0 before the next start.
- Continuous mode: n_rep=0, all D=0. phase_en rotates every cycle; rep_cnt increments every 4 cycles and wraps 255→0 with R=8; done never asserts; abort then stops it.
- Reset mid-run: rst=0 at one edge during RUN → all outputs 0 and state IDLE next cycle; a new start then behaves as in the basic run.
- Input priority:
  - start+abort together in IDLE → nothing happens.
  - abort together with tb_eo in RUN → ABT; phase_idx is not advanced.
  - start during RUN → ignored.
  - dur changed mid-run → original durations are used.
- Max duration: D0=255, D1..D3=0, n_rep=1 → phase 0 lasts 256 cycles, total RUN 259 cycles, then done.
